mem_bus_arbiter: RTL and testbench

Two-master arbiter that shares a single data-RAM port between instruction fetch (IF) and the load/store path (EX issue / MEM completion). It grants requests with load/store priority and an IF starvation guard. It records the issuing master of every accepted transaction in an in-order tag FIFO. It steers each `data_ok`/`rdata` response back to the master that issued it. It sits between the core stages and the RAM bus, upstream of the MEM stage's `dram_data_ok`/`dram_rdata` inputs.

---
 rtl/mem_bus_arbiter_if.sv | 24 ++
 rtl/mem_bus_arbiter.sv | 133 +++++++++++++
 tb/tb_mem_bus_arbiter.sv | 320 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_bus_arbiter_if.sv
// Request/response bus used for the IF, load/store and RAM sides of mem_bus_arbiter.
// The master modport issues requests; the slave modport accepts them and returns responses.
interface mem_bus_arbiter_if #(
    parameter int unsigned XLEN = 32
);
    logic              req;
    logic              write;
    logic [XLEN-1:0]   addr;
    logic [XLEN/8-1:0] wstrb;
    logic [XLEN-1:0]   wdata;
    logic              addr_ok;
    logic              data_ok;
    logic [XLEN-1:0]   rdata;

    modport master (
        output req, write, addr, wstrb, wdata,
        input  addr_ok, data_ok, rdata
    );

    modport slave (
        input  req, write, addr, wstrb, wdata,
        output addr_ok, data_ok, rdata
    );
endinterface

// File: rtl/mem_bus_arbiter.sv
// Shares one RAM port between instruction fetch (ibus) and load/store (dbus).
// Requests are granted with load/store priority and an IF starvation guard; responses are routed in order via a tag FIFO.
module mem_bus_arbiter #(
    parameter int unsigned XLEN            = 32,
    parameter int unsigned MAX_OUTSTANDING = 2,
    parameter int unsigned IF_STARVE       = 4
) (
    input  logic              clk,
    input  logic              rst_b,
    mem_bus_arbiter_if.slave  ibus,
    mem_bus_arbiter_if.slave  dbus,
    mem_bus_arbiter_if.master ram,
    output logic              err_unexpected
);
    localparam int unsigned PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING + 1);
    localparam int unsigned STV_W = $clog2(IF_STARVE + 1);

    localparam logic [CNT_W-1:0] CNT_MAX    = CNT_W'(MAX_OUTSTANDING);
    localparam logic [STV_W-1:0] STARVE_MAX = STV_W'(IF_STARVE);

    typedef enum logic { ID_IBUS = 1'b0, ID_DBUS = 1'b1 } master_e;
    typedef enum logic { LOCK_OPEN, LOCK_HELD } lock_e;

    lock_e                      lock_q, lock_d;
    master_e                    lock_id_q, lock_id_d;
    master_e                    grant;
    master_e                    head;
    logic                       granted_req;
    logic [MAX_OUTSTANDING-1:0] tag_q;
    logic [PTR_W-1:0]           wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]           count_q;
    logic [STV_W-1:0]           starve_q;
    logic                       full, empty, push, pop;
    logic                       unused_ibus_payload;

    assign unused_ibus_payload = ^{ibus.write, ibus.wstrb, ibus.wdata};

    assign full  = (count_q == CNT_MAX);
    assign empty = (count_q == '0);
    assign head  = master_e'(tag_q[rd_ptr_q]);

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            lock_q    <= LOCK_OPEN;
            lock_id_q <= ID_IBUS;
        end else begin
            lock_q    <= lock_d;
            lock_id_q <= lock_id_d;
        end
    end

    // A stalled handshake pins the grant so the RAM never sees the payload switch masters.
    always_comb begin
        lock_d      = lock_q;
        lock_id_d   = lock_id_q;
        grant       = ID_DBUS;
        granted_req = 1'b0;
        ram.req     = 1'b0;

        if (lock_q == LOCK_HELD) begin
            grant = lock_id_q;
        end else if (!dbus.req || (starve_q == STARVE_MAX)) begin
            grant = ID_IBUS;
        end else begin
            grant = ID_DBUS;
        end

        granted_req = (grant == ID_DBUS) ? dbus.req : ibus.req;
        ram.req     = granted_req & ~full;

        if (ram.req && !ram.addr_ok) begin
            lock_d    = LOCK_HELD;
            lock_id_d = grant;
        end else if (ram.addr_ok) begin
            lock_d = LOCK_OPEN;
        end
    end

    assign ram.write = (grant == ID_DBUS) & dbus.write;
    assign ram.addr  = (grant == ID_DBUS) ? dbus.addr  : ibus.addr;
    assign ram.wstrb = (grant == ID_DBUS) ? dbus.wstrb : '0;
    assign ram.wdata = (grant == ID_DBUS) ? dbus.wdata : '0;

    assign push = ram.req & ram.addr_ok;
    assign pop  = ram.data_ok & ~empty;

    assign ibus.addr_ok = push & (grant == ID_IBUS);
    assign dbus.addr_ok = push & (grant == ID_DBUS);

    assign ibus.data_ok = pop & (head == ID_IBUS);
    assign dbus.data_ok = pop & (head == ID_DBUS);
    assign ibus.rdata   = ram.rdata;
    assign dbus.rdata   = ram.rdata;

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            tag_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                tag_q[wr_ptr_q] <= grant;
                wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            starve_q       <= '0;
            err_unexpected <= 1'b0;
        end else begin
            if (ibus.addr_ok || !ibus.req) begin
                starve_q <= '0;
            end else if (dbus.addr_ok && (starve_q != STARVE_MAX)) begin
                starve_q <= starve_q + STV_W'(1);
            end
            if (ram.data_ok && empty) begin
                err_unexpected <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter: inputs change 1 time unit after the rising edge,
// combinational outputs are sampled 1 unit later, well before the next edge.
module tb_mem_bus_arbiter;
    localparam int unsigned XLEN = 32;

    logic        clk = 1'b0;
    logic        rst_b;
    logic        err_unexpected;
    int unsigned n_pass  = 0;
    int unsigned n_total = 0;

    mem_bus_arbiter_if #(.XLEN(XLEN)) ibus_if ();
    mem_bus_arbiter_if #(.XLEN(XLEN)) dbus_if ();
    mem_bus_arbiter_if #(.XLEN(XLEN)) ram_if ();

    mem_bus_arbiter #(
        .XLEN(XLEN),
        .MAX_OUTSTANDING(2),
        .IF_STARVE(4)
    ) dut (
        .clk(clk),
        .rst_b(rst_b),
        .ibus(ibus_if),
        .dbus(dbus_if),
        .ram(ram_if),
        .err_unexpected(err_unexpected)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        ibus_if.req   = 1'b0;
        ibus_if.write = 1'b0;
        ibus_if.addr  = '0;
        ibus_if.wstrb = '0;
        ibus_if.wdata = '0;
        dbus_if.req   = 1'b0;
        dbus_if.write = 1'b0;
        dbus_if.addr  = '0;
        dbus_if.wstrb = '0;
        dbus_if.wdata = '0;
        ram_if.addr_ok = 1'b0;
        ram_if.data_ok = 1'b0;
        ram_if.rdata   = '0;
    endtask

    task automatic test_reset();
        rst_b = 1'b0;
        idle();
        #1;
        n_total++; if (ram_if.req !== 1'b0) $display("FAIL reset_ram_req: got %b want 0", ram_if.req); else n_pass++;
        n_total++; if (ibus_if.addr_ok !== 1'b0) $display("FAIL reset_ibus_addr_ok: got %b want 0", ibus_if.addr_ok); else n_pass++;
        n_total++; if (dbus_if.addr_ok !== 1'b0) $display("FAIL reset_dbus_addr_ok: got %b want 0", dbus_if.addr_ok); else n_pass++;
        n_total++; if (err_unexpected !== 1'b0) $display("FAIL reset_err: got %b want 0", err_unexpected); else n_pass++;
        ram_if.data_ok = 1'b1;
        #1;
        n_total++; if (ibus_if.data_ok !== 1'b0) $display("FAIL reset_ibus_data_ok: got %b want 0", ibus_if.data_ok); else n_pass++;
        n_total++; if (dbus_if.data_ok !== 1'b0) $display("FAIL reset_dbus_data_ok: got %b want 0", dbus_if.data_ok); else n_pass++;
        ram_if.data_ok = 1'b0;
        ibus_if.req    = 1'b1;
        ram_if.addr_ok = 1'b1;
        #1;
        n_total++; if (ram_if.req !== 1'b1) $display("FAIL reset_req_follows: got %b want 1", ram_if.req); else n_pass++;
        idle();
        #4;
        rst_b = 1'b1;
    endtask

    task automatic test_single_ibus();
        step();
        ibus_if.req    = 1'b1;
        ibus_if.addr   = 32'h0000_0100;
        ram_if.addr_ok = 1'b1;
        #1;
        n_total++; if (ram_if.addr !== 32'h100) $display("FAIL single_ram_addr: got %h want 00000100", ram_if.addr); else n_pass++;
        n_total++; if (ram_if.write !== 1'b0 || ram_if.wstrb !== 4'h0) $display("FAIL single_ram_wr: got %b/%h want 0/0", ram_if.write, ram_if.wstrb); else n_pass++;
        n_total++; if (ibus_if.addr_ok !== 1'b1) $display("FAIL single_ibus_addr_ok: got %b want 1", ibus_if.addr_ok); else n_pass++;
        n_total++; if (dbus_if.addr_ok !== 1'b0) $display("FAIL single_dbus_addr_ok: got %b want 0", dbus_if.addr_ok); else n_pass++;
        step();
        idle();
        #1;
        n_total++; if (ram_if.req !== 1'b0) $display("FAIL single_req_drop: got %b want 0", ram_if.req); else n_pass++;
        step();
        step();
        ram_if.data_ok = 1'b1;
        ram_if.rdata   = 32'hDEAD_BEEF;
        #1;
        n_total++; if (ibus_if.data_ok !== 1'b1) $display("FAIL single_ibus_data_ok: got %b want 1", ibus_if.data_ok); else n_pass++;
        n_total++; if (ibus_if.rdata !== 32'hDEAD_BEEF) $display("FAIL single_ibus_rdata: got %h want deadbeef", ibus_if.rdata); else n_pass++;
        n_total++; if (dbus_if.data_ok !== 1'b0) $display("FAIL single_dbus_data_ok: got %b want 0", dbus_if.data_ok); else n_pass++;
        step();
        idle();
        #1;
        n_total++; if (ibus_if.data_ok !== 1'b0) $display("FAIL single_data_ok_drop: got %b want 0", ibus_if.data_ok); else n_pass++;
    endtask

    task automatic test_both_masters();
        step();
        ibus_if.req    = 1'b1;
        ibus_if.addr   = 32'h0000_0200;
        dbus_if.req    = 1'b1;
        dbus_if.addr   = 32'h0000_0300;
        ram_if.addr_ok = 1'b1;
        #1;
        n_total++; if (dbus_if.addr_ok !== 1'b1 || ibus_if.addr_ok !== 1'b0) $display("FAIL both_first_grant: got d=%b i=%b want d=1 i=0", dbus_if.addr_ok, ibus_if.addr_ok); else n_pass++;
        n_total++; if (ram_if.addr !== 32'h300) $display("FAIL both_first_addr: got %h want 00000300", ram_if.addr); else n_pass++;
        step();
        dbus_if.req    = 1'b0;
        ram_if.data_ok = 1'b1;
        ram_if.rdata   = 32'h1111_1111;
        #1;
        n_total++; if (ibus_if.addr_ok !== 1'b1 || dbus_if.addr_ok !== 1'b0) $display("FAIL both_second_grant: got i=%b d=%b want i=1 d=0", ibus_if.addr_ok, dbus_if.addr_ok); else n_pass++;
        n_total++; if (ram_if.addr !== 32'h200) $display("FAIL both_second_addr: got %h want 00000200", ram_if.addr); else n_pass++;
        n_total++; if (dbus_if.data_ok !== 1'b1 || ibus_if.data_ok !== 1'b0) $display("FAIL both_resp_d: got d=%b i=%b want d=1 i=0", dbus_if.data_ok, ibus_if.data_ok); else n_pass++;
        step();
        ibus_if.req    = 1'b0;
        ram_if.addr_ok = 1'b0;
        ram_if.rdata   = 32'h2222_2222;
        #1;
        n_total++; if (ibus_if.data_ok !== 1'b1 || dbus_if.data_ok !== 1'b0) $display("FAIL both_resp_i: got i=%b d=%b want i=1 d=0", ibus_if.data_ok, dbus_if.data_ok); else n_pass++;
        n_total++; if (ibus_if.rdata !== 32'h2222_2222) $display("FAIL both_resp_rdata: got %h want 22222222", ibus_if.rdata); else n_pass++;
        step();
        idle();
    endtask

    task automatic test_lock();
        step();
        dbus_if.req    = 1'b1;
        dbus_if.write  = 1'b1;
        dbus_if.addr   = 32'h0000_0400;
        dbus_if.wstrb  = 4'h3;
        dbus_if.wdata  = 32'h0000_CAFE;
        ibus_if.req    = 1'b1;
        ibus_if.addr   = 32'h0000_0500;
        ram_if.addr_ok = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_total++; if (ram_if.req !== 1'b1 || ram_if.write !== 1'b1) $display("FAIL lock_stall_req[%0d]: got req=%b wr=%b want 1/1", i, ram_if.req, ram_if.write); else n_pass++;
            n_total++; if (ram_if.addr !== 32'h400 || ram_if.wstrb !== 4'h3) $display("FAIL lock_stall_payload[%0d]: got %h/%h want 00000400/3", i, ram_if.addr, ram_if.wstrb); else n_pass++;
            n_total++; if (ibus_if.addr_ok !== 1'b0 || dbus_if.addr_ok !== 1'b0) $display("FAIL lock_stall_ok[%0d]: got i=%b d=%b want 0/0", i, ibus_if.addr_ok, dbus_if.addr_ok); else n_pass++;
            step();
        end
        ram_if.addr_ok = 1'b1;
        #1;
        n_total++; if (dbus_if.addr_ok !== 1'b1 || ram_if.wdata !== 32'hCAFE) $display("FAIL lock_store_accept: got ok=%b wdata=%h want 1/0000cafe", dbus_if.addr_ok, ram_if.wdata); else n_pass++;
        step();
        dbus_if.req    = 1'b0;
        dbus_if.write  = 1'b0;
        ram_if.data_ok = 1'b1;
        #1;
        n_total++; if (ibus_if.addr_ok !== 1'b1 || ram_if.addr !== 32'h500) $display("FAIL lock_ibus_after: got ok=%b addr=%h want 1/00000500", ibus_if.addr_ok, ram_if.addr); else n_pass++;
        n_total++; if (dbus_if.data_ok !== 1'b1) $display("FAIL lock_store_done: got %b want 1", dbus_if.data_ok); else n_pass++;
        step();
        ibus_if.req    = 1'b0;
        ram_if.addr_ok = 1'b0;
        #1;
        n_total++; if (ibus_if.data_ok !== 1'b1) $display("FAIL lock_ibus_resp: got %b want 1", ibus_if.data_ok); else n_pass++;
        step();
        idle();

        // IBUS stalls first; a later DBUS request must not steal the locked grant.
        step();
        ibus_if.req  = 1'b1;
        ibus_if.addr = 32'h0000_0600;
        #1;
        n_total++; if (ram_if.addr !== 32'h600) $display("FAIL lock2_start_addr: got %h want 00000600", ram_if.addr); else n_pass++;
        step();
        dbus_if.req   = 1'b1;
        dbus_if.write = 1'b1;
        dbus_if.wstrb = 4'hF;
        dbus_if.addr  = 32'h0000_0700;
        #1;
        n_total++; if (ram_if.addr !== 32'h600 || ram_if.write !== 1'b0 || ram_if.wstrb !== 4'h0) $display("FAIL lock2_held: got %h/%b/%h want 00000600/0/0", ram_if.addr, ram_if.write, ram_if.wstrb); else n_pass++;
        step();
        ram_if.addr_ok = 1'b1;
        #1;
        n_total++; if (ibus_if.addr_ok !== 1'b1 || dbus_if.addr_ok !== 1'b0) $display("FAIL lock2_accept: got i=%b d=%b want 1/0", ibus_if.addr_ok, dbus_if.addr_ok); else n_pass++;
        step();
        ibus_if.req    = 1'b0;
        ram_if.data_ok = 1'b1;
        #1;
        n_total++; if (dbus_if.addr_ok !== 1'b1 || ram_if.addr !== 32'h700) $display("FAIL lock2_dbus_next: got ok=%b addr=%h want 1/00000700", dbus_if.addr_ok, ram_if.addr); else n_pass++;
        n_total++; if (ibus_if.data_ok !== 1'b1 || dbus_if.data_ok !== 1'b0) $display("FAIL lock2_resp_i: got i=%b d=%b want 1/0", ibus_if.data_ok, dbus_if.data_ok); else n_pass++;
        step();
        dbus_if.req    = 1'b0;
        ram_if.addr_ok = 1'b0;
        #1;
        n_total++; if (dbus_if.data_ok !== 1'b1 || ibus_if.data_ok !== 1'b0) $display("FAIL lock2_resp_d: got d=%b i=%b want 1/0", dbus_if.data_ok, ibus_if.data_ok); else n_pass++;
        step();
        idle();
    endtask

    task automatic test_starvation();
        logic [9:0] want_d;
        want_d = 10'b0111101111;
        for (int i = 0; i < 10; i++) begin
            step();
            ibus_if.req    = 1'b1;
            ibus_if.addr   = 32'h0000_1000;
            dbus_if.req    = 1'b1;
            dbus_if.addr   = 32'h0000_2000;
            ram_if.addr_ok = 1'b1;
            ram_if.data_ok = (i > 0);
            #1;
            n_total++; if (dbus_if.addr_ok !== want_d[i] || ibus_if.addr_ok !== ~want_d[i]) $display("FAIL starve_grant[%0d]: got d=%b i=%b want d=%b", i, dbus_if.addr_ok, ibus_if.addr_ok, want_d[i]); else n_pass++;
            n_total++; if (ram_if.addr !== (want_d[i] ? 32'h2000 : 32'h1000)) $display("FAIL starve_addr[%0d]: got %h want d=%b", i, ram_if.addr, want_d[i]); else n_pass++;
            if (i > 0) begin
                n_total++; if (dbus_if.data_ok !== want_d[i-1] || ibus_if.data_ok !== ~want_d[i-1]) $display("FAIL starve_route[%0d]: got d=%b i=%b want d=%b", i, dbus_if.data_ok, ibus_if.data_ok, want_d[i-1]); else n_pass++;
            end
        end
        step();
        ibus_if.req    = 1'b0;
        dbus_if.req    = 1'b0;
        ram_if.addr_ok = 1'b0;
        ram_if.data_ok = 1'b1;
        #1;
        n_total++; if (ibus_if.data_ok !== 1'b1 || dbus_if.data_ok !== 1'b0) $display("FAIL starve_last_route: got i=%b d=%b want 1/0", ibus_if.data_ok, dbus_if.data_ok); else n_pass++;
        step();
        idle();
    endtask

    task automatic test_fifo_full();
        step();
        dbus_if.req    = 1'b1;
        dbus_if.addr   = 32'h0000_0800;
        ram_if.addr_ok = 1'b1;
        #1;
        n_total++; if (dbus_if.addr_ok !== 1'b1) $display("FAIL full_accept0: got %b want 1", dbus_if.addr_ok); else n_pass++;
        step();
        #1;
        n_total++; if (dbus_if.addr_ok !== 1'b1) $display("FAIL full_accept1: got %b want 1", dbus_if.addr_ok); else n_pass++;
        step();
        #1;
        n_total++; if (ram_if.req !== 1'b0 || dbus_if.addr_ok !== 1'b0) $display("FAIL full_block: got req=%b ok=%b want 0/0", ram_if.req, dbus_if.addr_ok); else n_pass++;
        step();
        ram_if.data_ok = 1'b1;
        #1;
        n_total++; if (ram_if.req !== 1'b0) $display("FAIL full_no_bypass: got %b want 0", ram_if.req); else n_pass++;
        n_total++; if (dbus_if.data_ok !== 1'b1) $display("FAIL full_pop: got %b want 1", dbus_if.data_ok); else n_pass++;
        step();
        ram_if.data_ok = 1'b0;
        #1;
        n_total++; if (ram_if.req !== 1'b1 || dbus_if.addr_ok !== 1'b1) $display("FAIL full_reassert: got req=%b ok=%b want 1/1", ram_if.req, dbus_if.addr_ok); else n_pass++;
        step();
        dbus_if.req    = 1'b0;
        ram_if.addr_ok = 1'b0;
        ram_if.data_ok = 1'b1;
        #1;
        n_total++; if (dbus_if.data_ok !== 1'b1) $display("FAIL full_drain0: got %b want 1", dbus_if.data_ok); else n_pass++;
        step();
        #1;
        n_total++; if (dbus_if.data_ok !== 1'b1) $display("FAIL full_drain1: got %b want 1", dbus_if.data_ok); else n_pass++;
        step();
        idle();
    endtask

    task automatic test_unexpected_and_reset();
        step();
        ram_if.data_ok = 1'b1;
        #1;
        n_total++; if (ibus_if.data_ok !== 1'b0 || dbus_if.data_ok !== 1'b0) $display("FAIL unexp_no_route: got i=%b d=%b want 0/0", ibus_if.data_ok, dbus_if.data_ok); else n_pass++;
        step();
        ram_if.data_ok = 1'b0;
        #1;
        n_total++; if (err_unexpected !== 1'b1) $display("FAIL unexp_err_set: got %b want 1", err_unexpected); else n_pass++;
        step();
        dbus_if.req    = 1'b1;
        dbus_if.addr   = 32'h0000_0900;
        ram_if.addr_ok = 1'b1;
        #1;
        n_total++; if (err_unexpected !== 1'b1) $display("FAIL unexp_err_sticky: got %b want 1", err_unexpected); else n_pass++;
        step();
        step();
        #1;
        n_total++; if (ram_if.req !== 1'b0) $display("FAIL unexp_two_outstanding: got %b want 0", ram_if.req); else n_pass++;
        #1;
        rst_b = 1'b0;
        #1;
        n_total++; if (ram_if.req !== 1'b1 || dbus_if.addr_ok !== 1'b1) $display("FAIL areset_req_follows: got req=%b ok=%b want 1/1", ram_if.req, dbus_if.addr_ok); else n_pass++;
        n_total++; if (err_unexpected !== 1'b0) $display("FAIL areset_err_clear: got %b want 0", err_unexpected); else n_pass++;
        dbus_if.req    = 1'b0;
        ram_if.addr_ok = 1'b0;
        ram_if.data_ok = 1'b1;
        #1;
        n_total++; if (ibus_if.data_ok !== 1'b0 || dbus_if.data_ok !== 1'b0) $display("FAIL areset_tags_gone: got i=%b d=%b want 0/0", ibus_if.data_ok, dbus_if.data_ok); else n_pass++;
        ram_if.data_ok = 1'b0;
        #1;
        rst_b = 1'b1;
        step();
        ram_if.data_ok = 1'b1;
        #1;
        n_total++; if (dbus_if.data_ok !== 1'b0 || ibus_if.data_ok !== 1'b0) $display("FAIL late_resp_route: got d=%b i=%b want 0/0", dbus_if.data_ok, ibus_if.data_ok); else n_pass++;
        step();
        ram_if.data_ok = 1'b0;
        #1;
        n_total++; if (err_unexpected !== 1'b1) $display("FAIL late_resp_err: got %b want 1", err_unexpected); else n_pass++;
        rst_b = 1'b0;
        #2;
        rst_b = 1'b1;
        #1;
        n_total++; if (err_unexpected !== 1'b0) $display("FAIL final_reset_err: got %b want 0", err_unexpected); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_single_ibus();
        test_both_masters();
        test_lock();
        test_starvation();
        test_fifo_full();
        test_unexpected_and_reset();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
